// File: rtl/halt_control_unit.sv
// Halt control unit: detects EBREAK / ECALL / external debug halt triggers at
// decode, freezes fetch, lets older instructions drain for PIPE_DEPTH cycles,
// then parks in HALTED until a resume pulse. Also keeps halt statistics.
module halt_control_unit #(
    parameter int PIPE_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       inst,
    input  logic [2:0]       funct3,
    input  logic             ebreak_bit,
    input  logic [2:0]       halt_en,
    input  logic             ext_halt_req,
    input  logic             resume,
    output logic             pc_hold,
    output logic             if_flush,
    output logic             draining,
    output logic             halted,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] halt_count,
    output logic [CNT_W-1:0] halted_cycles
);

    localparam logic [4:0] OPCODE_SYSTEM = 5'b11100;

    // Drain counter only needs to hold PIPE_DEPTH-1.
    localparam int DCW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
    localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(PIPE_DEPTH - 1);

    localparam logic [1:0] CAUSE_EBREAK = 2'b01;
    localparam logic [1:0] CAUSE_ECALL  = 2'b10;
    localparam logic [1:0] CAUSE_EXT    = 2'b11;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DRAIN  = 2'b01,
        HALTED = 2'b10
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [DCW-1:0] drain_cnt;
    logic [DCW-1:0] drain_cnt_nxt;

    logic sys_trap;
    logic trig_ebk;
    logic trig_ecl;
    logic trig_ext;
    logic trigger;

    // Saturating increment: sticks at all-ones once reached.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Cause encoding with EBREAK > ECALL > external priority.
    function automatic logic [1:0] encode_cause(input logic ebk, input logic ecl);
        if (ebk)      return CAUSE_EBREAK;
        else if (ecl) return CAUSE_ECALL;
        else          return CAUSE_EXT;
    endfunction

    // The ext source is deliberately independent of id_valid: a bubble in
    // decode must not mask a debugger request.
    assign sys_trap = id_valid && (inst == OPCODE_SYSTEM) && (funct3 == 3'b000);
    assign trig_ebk = sys_trap &&  ebreak_bit && halt_en[0];
    assign trig_ecl = sys_trap && !ebreak_bit && halt_en[1];
    assign trig_ext = ext_halt_req && halt_en[2];
    assign trigger  = (state == RUN) && (trig_ebk || trig_ecl || trig_ext);

    // Combinational outputs so fetch freezes in the trigger cycle itself.
    assign pc_hold  = trigger || (state != RUN);
    assign if_flush = trigger;
    assign draining = (state == DRAIN);
    assign halted   = (state == HALTED);

    // Next-state and drain counter logic.
    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        case (state)
            RUN: begin
                if (trigger) begin
                    state_nxt     = DRAIN;
                    drain_cnt_nxt = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) begin
                    state_nxt = HALTED;
                end else begin
                    drain_cnt_nxt = drain_cnt - 1'b1;
                end
            end
            HALTED: begin
                if (resume) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt     = RUN;
                drain_cnt_nxt = '0;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    // Halt cause capture and statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            halt_cause    <= 2'b00;
            halt_count    <= '0;
            halted_cycles <= '0;
        end else begin
            if (trigger) begin
                halt_cause <= encode_cause(trig_ebk, trig_ecl);
                halt_count <= sat_inc(halt_count);
            end
            if (state == HALTED) begin
                halted_cycles <= halted_cycles + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_halt_control_unit.sv
// Scoreboard bench for halt_control_unit: the stimulus process pushes the
// hand-computed expected outputs for each driven cycle; the monitor pops and
// compares on the falling edge. A second instance with CNT_W=2 shares the
// inputs to observe halt_count saturation and halted_cycles wrap.
module tb_halt_control_unit;

    localparam logic [4:0] SYS = 5'b11100;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  inst;
    logic [2:0]  funct3;
    logic        ebreak_bit;
    logic [2:0]  halt_en;
    logic        ext_halt_req;
    logic        resume;

    logic        pc_hold, if_flush, draining, halted;
    logic [1:0]  halt_cause;
    logic [15:0] halt_count, halted_cycles;

    logic        pc_hold2, if_flush2, draining2, halted2;
    logic [1:0]  halt_cause2;
    logic [1:0]  halt_count2, halted_cycles2;

    typedef struct {
        string      name;
        logic [3:0] flags;   // {pc_hold, if_flush, draining, halted}
        logic [1:0] cause;
        int         cnt;
        int         hc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic end_req = 1'b0;
    logic end_done = 1'b0;

    always #5 clk = ~clk;

    halt_control_unit #(.PIPE_DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .inst(inst), .funct3(funct3),
        .ebreak_bit(ebreak_bit), .halt_en(halt_en), .ext_halt_req(ext_halt_req),
        .resume(resume), .pc_hold(pc_hold), .if_flush(if_flush), .draining(draining),
        .halted(halted), .halt_cause(halt_cause), .halt_count(halt_count),
        .halted_cycles(halted_cycles)
    );

    halt_control_unit #(.PIPE_DEPTH(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .inst(inst), .funct3(funct3),
        .ebreak_bit(ebreak_bit), .halt_en(halt_en), .ext_halt_req(ext_halt_req),
        .resume(resume), .pc_hold(pc_hold2), .if_flush(if_flush2), .draining(draining2),
        .halted(halted2), .halt_cause(halt_cause2), .halt_count(halt_count2),
        .halted_cycles(halted_cycles2)
    );

    // Monitor: pop one expectation per driven cycle and compare both instances.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            int   sat_cnt;
            e = sb.pop_front();
            checks++;
            if ({pc_hold, if_flush, draining, halted} !== e.flags ||
                halt_cause !== e.cause || halt_count !== 16'(e.cnt) ||
                halted_cycles !== 16'(e.hc)) begin
                errors++;
                $display("FAIL %s: got ph/fl/dr/hl=%b cause=%b cnt=%0d hcyc=%0d, expected %b cause=%b cnt=%0d hcyc=%0d",
                         e.name, {pc_hold, if_flush, draining, halted}, halt_cause,
                         halt_count, halted_cycles, e.flags, e.cause, e.cnt, e.hc);
            end
            sat_cnt = (e.cnt > 3) ? 3 : e.cnt;
            checks++;
            if ({pc_hold2, if_flush2, draining2, halted2} !== e.flags ||
                halt_count2 !== 2'(sat_cnt) || halted_cycles2 !== 2'(e.hc % 4)) begin
                errors++;
                $display("FAIL %s_cntw2: got flags=%b cnt=%0d hcyc=%0d, expected flags=%b cnt=%0d hcyc=%0d",
                         e.name, {pc_hold2, if_flush2, draining2, halted2}, halt_count2,
                         halted_cycles2, e.flags, sat_cnt, e.hc % 4);
            end
        end else if (end_req && !end_done) begin
            end_done <= 1'b1;
            checks++;
            if (sb.size() != 0) begin
                errors++;
                $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input string nm, input logic [3:0] fl, input logic [1:0] c,
                      input int cnt, input int hc);
        exp_t e;
        e.name  = nm;
        e.flags = fl;
        e.cause = c;
        e.cnt   = cnt;
        e.hc    = hc;
        sb.push_back(e);
    endtask

    // Flag patterns: idle 0000, trigger 1100, drain 1010, halted 1001.
    initial begin
        rst = 1'b1; id_valid = 1'b0; inst = 5'd0; funct3 = 3'd0; ebreak_bit = 1'b0;
        halt_en = 3'b111; ext_halt_req = 1'b0; resume = 1'b0;

        tick(); ex("reset", 4'b0000, 2'b00, 0, 0);
        tick(); rst = 1'b0; ex("idle", 4'b0000, 2'b00, 0, 0);
        tick(); id_valid = 1'b1; inst = 5'b01100; ebreak_bit = 1'b1;
        ex("non_system_op", 4'b0000, 2'b00, 0, 0);
        tick(); id_valid = 1'b0; inst = SYS; ex("bubble_ebreak", 4'b0000, 2'b00, 0, 0);
        tick(); id_valid = 1'b1; funct3 = 3'b001; ex("csr_not_trap", 4'b0000, 2'b00, 0, 0);

        // EBREAK halt; resume during DRAIN must be ignored.
        tick(); funct3 = 3'b000; ebreak_bit = 1'b1; ex("ebk_trigger", 4'b1100, 2'b00, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(); id_valid = 1'b0; resume = (i == 1);
            ex("ebk_drain", 4'b1010, 2'b01, 1, 0);
        end
        tick(); resume = 1'b0; ex("ebk_halted", 4'b1001, 2'b01, 1, 0);
        tick(); resume = 1'b1; ex("ebk_resume", 4'b1001, 2'b01, 1, 1);
        tick(); resume = 1'b0; ex("ebk_run", 4'b0000, 2'b01, 1, 2);

        // ECALL masked, then enabled.
        tick(); id_valid = 1'b1; ebreak_bit = 1'b0; halt_en = 3'b101;
        ex("ecall_masked", 4'b0000, 2'b01, 1, 2);
        tick(); halt_en = 3'b111; ex("ecall_trigger", 4'b1100, 2'b01, 1, 2);
        for (int i = 0; i < 4; i++) begin
            tick(); id_valid = 1'b0; ex("ecall_drain", 4'b1010, 2'b10, 2, 2);
        end
        tick(); ex("ecall_halted", 4'b1001, 2'b10, 2, 2);
        tick(); resume = 1'b1; ex("ecall_resume", 4'b1001, 2'b10, 2, 3);
        tick(); resume = 1'b0; ex("ecall_run", 4'b0000, 2'b10, 2, 4);

        // EBREAK and external together; ext held through DRAIN changes nothing.
        tick(); id_valid = 1'b1; ebreak_bit = 1'b1; ext_halt_req = 1'b1;
        ex("ebk_ext_trigger", 4'b1100, 2'b10, 2, 4);
        for (int i = 0; i < 4; i++) begin
            tick(); id_valid = 1'b0; ex("ebk_ext_drain", 4'b1010, 2'b01, 3, 4);
        end

        // Ten HALTED cycles, resume in the tenth: halted_cycles advances by 10.
        for (int i = 0; i < 10; i++) begin
            tick(); ext_halt_req = 1'b0; resume = (i == 9);
            ex("halted_10", 4'b1001, 2'b01, 3, 4 + i);
        end
        tick(); resume = 1'b0; ex("resume_run", 4'b0000, 2'b01, 3, 14);
        tick(); ex("no_retrigger", 4'b0000, 2'b01, 3, 14);

        // External halt, resumed while still requested: re-trigger in first RUN cycle.
        tick(); ext_halt_req = 1'b1; ex("ext_trigger", 4'b1100, 2'b01, 3, 14);
        for (int i = 0; i < 4; i++) begin
            tick(); ex("ext_drain", 4'b1010, 2'b11, 4, 14);
        end
        tick(); ex("ext_halted", 4'b1001, 2'b11, 4, 14);
        tick(); resume = 1'b1; ex("resume_with_ext", 4'b1001, 2'b11, 4, 15);
        tick(); resume = 1'b0; ex("ext_retrigger", 4'b1100, 2'b11, 4, 16);
        tick(); ext_halt_req = 1'b0; ex("retrig_drain1", 4'b1010, 2'b11, 5, 16);

        // Reset in DRAIN cycle 2.
        tick(); rst = 1'b1; ex("rst_in_drain", 4'b1010, 2'b11, 5, 16);
        tick(); rst = 1'b0; ex("after_rst", 4'b0000, 2'b00, 0, 0);
        tick(); ex("after_rst_idle", 4'b0000, 2'b00, 0, 0);

        // Disabled sources never trigger.
        tick(); halt_en = 3'b110; id_valid = 1'b1; inst = SYS; funct3 = 3'b000; ebreak_bit = 1'b1;
        ex("ebreak_disabled", 4'b0000, 2'b00, 0, 0);
        tick(); id_valid = 1'b0; halt_en = 3'b011; ext_halt_req = 1'b1;
        ex("ext_disabled", 4'b0000, 2'b00, 0, 0);

        // Halt in progress completes after all enables are cleared.
        tick(); halt_en = 3'b111; ex("ext_trigger2", 4'b1100, 2'b00, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(); halt_en = 3'b000; ext_halt_req = 1'b0;
            ex("drain_en_cleared", 4'b1010, 2'b11, 1, 0);
        end
        tick(); ex("halted_en_cleared", 4'b1001, 2'b11, 1, 0);
        tick(); resume = 1'b1; ex("resume2", 4'b1001, 2'b11, 1, 1);
        tick(); resume = 1'b0; ex("run2", 4'b0000, 2'b11, 1, 2);

        tick(); end_req = 1'b1;
        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
